uart_sdram_bridge: RTL and testbench
====================================

Name: uart_sdram_bridge

Overview:
Parametrised UART-to-SDRAM command bridge that sits between the uart byte interface and sdram_ctrl in the FPGA top level. It parses host byte commands for single write, single read and burst read. Addresses and data span multiple bytes (MSB first). The block returns read data, a write acknowledge, or an error byte over UART, and aborts partial commands after an inter-byte timeout.

Parameters:
AddrWidth, 22, SDRAM word address width; AddrBytes = ceil(AddrWidth/8) is a derived localparam.
DataWidth, 16, SDRAM word width; must be a multiple of 8; DataBytes = DataWidth/8 is a derived localparam.
TimeoutCycles, 1_330_000, idle clock cycles allowed between bytes of one command; minimum 2.
EnableAck, 1, 1 = transmit 0x6B ('k') after each completed write; 0 = no write response.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  received UART byte, valid while i_rx_rdy=1
i_rx_rdy  in  1  UART has a byte pending
o_rx_req  out  1  one-cycle pulse; consumes the current rx byte
o_tx_data  out  8  byte to transmit, valid while o_tx_req=1
o_tx_req  out  1  one-cycle transmit strobe
i_tx_rdy  in  1  UART transmitter idle
i_ctrl_rdy  in  1  sdram_ctrl can accept a request
o_wr_req  out  1  one-cycle write request
o_wr_addr  out  AddrWidth  write word address
o_wr_data  out  DataWidth  write word
o_rd_req  out  1  one-cycle read request
o_rd_addr  out  AddrWidth  read word address
i_rd_data  in  DataWidth  read word, valid when i_rd_rdy=1
i_rd_rdy  in  1  read data strobe
o_busy  out  1  high whenever the FSM is not in IDLE
o_err  out  1  one-cycle pulse on an invalid command or timeout

Behaviour:
- Reset (async, i_rst_n=0): all outputs are 0, the FSM is in IDLE, and all counters and registers are cleared. A reset mid-command drops any pending request immediately. No partial write is issued.
- Commands: 0x77 'w' = AddrBytes address bytes + DataBytes data bytes. 0x72 'r' = address bytes. 0x62 'b' = address bytes + 1 count byte C; reads C+1 words (1..256).
- Multi-byte fields are MSB first. Address bits above AddrWidth are discarded.
- RX handshake: a byte is taken only in a state that needs one. When i_rx_rdy=1 and o_rx_req was 0 in the previous cycle, the block pulses o_rx_req for one cycle and latches i_rx_data in that same cycle. i_rx_rdy is ignored in all other states, and the byte stays pending in the uart.
- TX handshake: when i_tx_rdy=1 and o_tx_req was 0 in the previous cycle, the block pulses o_tx_req with o_tx_data valid. The byte counts as sent at the pulse. The next byte waits at least one cycle and then for i_tx_rdy=1.
- DRAM requests: o_wr_req/o_rd_req pulse for one cycle only while i_ctrl_rdy=1. The block waits in the issue state while i_ctrl_rdy=0. o_wr_addr, o_wr_data and o_rd_addr are held stable from the pulse until the next request.
- FSM states:
  - IDLE: pop a byte, then go to DECODE.
  - DECODE: known command → GET_ADDR. Any other byte → ERR.
  - GET_ADDR: collect AddrBytes bytes, then go to GET_DATA ('w'), RD_ISSUE ('r') or GET_LEN ('b').
  - GET_LEN: collect the count byte, then RD_ISSUE.
  - GET_DATA: collect DataBytes bytes, then WR_ISSUE.
  - WR_ISSUE: issue the write; go to ACK if EnableAck=1, otherwise IDLE.
  - RD_ISSUE: issue the read, then RD_WAIT.
  - RD_WAIT: on i_rd_rdy, latch i_rd_data, then TX_DATA.
  - TX_DATA: send DataBytes bytes MSB first. If words remain, increment the address and go to RD_ISSUE; otherwise IDLE.
  - ACK: send 0x6B, then IDLE.
  - ERR: pulse o_err, send 0x3F ('?'), then IDLE.
- Burst address arithmetic: each next word address is the previous address + 1, modulo 2^AddrWidth (0x3FFFFF wraps to 0x000000). The word counter is 9 bits and counts down from C+1.
- Timeout:
  - The counter clears on every popped byte and on entry to GET_ADDR; it only counts in GET_ADDR, GET_LEN and GET_DATA.
  - When the count reaches TimeoutCycles-1, pulse o_err, go to IDLE, issue no request and send no response byte.
- There is no timeout in RD_WAIT or TX states; the block waits indefinitely there.
- i_rd_rdy outside RD_WAIT is ignored.

Test Plan:
- Write, AddrWidth=22/DataWidth=16: rx 77 12 34 56 AB CD → one o_wr_req with o_wr_addr=0x123456 and o_wr_data=0xABCD, then tx 6B.
- Single read: rx 72 3F FF FF, i_rd_data=0xBEEF → o_rd_addr=0x3FFFFF, then tx BE, EF; o_busy falls afterwards.
- Burst wrap: rx 62 3F FF FE 02 with the read data model returning 0x0001, 0x0002, 0x0003 → reads at 0x3FFFFE, 0x3FFFFF, 0x000000; tx 00 01 00 02 00 03.
- Invalid command and timeout: rx 0x41 → o_err pulse, tx 3F. Then rx 77 12 followed by TimeoutCycles idle cycles → o_err pulse, no o_wr_req, no tx, FSM back in IDLE.
- Backpressure: i_ctrl_rdy=0 for 50 cycles during WR_ISSUE, and i_tx_rdy=0 during TX_DATA → no request or tx strobe until the ready input rises, then exactly one pulse each.
- Reset mid-burst: assert i_rst_n=0 during RD_WAIT → all outputs 0 asynchronously; after release, a new 'r' command completes normally.

Source files
------------

// File: rtl/uart_sdram_bridge.sv
// rtl/uart_sdram_bridge.sv - UART byte-command to SDRAM request bridge
// Parses 'w'/'r'/'b' host commands, issues SDRAM requests, and returns data, ack or error bytes.
module uart_sdram_bridge #(
    parameter int AddrWidth     = 22,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 1_330_000,
    parameter int EnableAck     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_rdy,
    output logic                 o_rx_req,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_req,
    input  logic                 i_tx_rdy,
    input  logic                 i_ctrl_rdy,
    output logic                 o_wr_req,
    output logic [AddrWidth-1:0] o_wr_addr,
    output logic [DataWidth-1:0] o_wr_data,
    output logic                 o_rd_req,
    output logic [AddrWidth-1:0] o_rd_addr,
    input  logic [DataWidth-1:0] i_rd_data,
    input  logic                 i_rd_rdy,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int AddrBytes = (AddrWidth + 7) / 8;
    localparam int DataBytes = DataWidth / 8;
    localparam int TmoW      = $clog2(TimeoutCycles);
    localparam logic [7:0] CmdWr = 8'h77, CmdRd = 8'h72, CmdBurst = 8'h62;
    localparam logic [7:0] RespAck = 8'h6B, RespErr = 8'h3F;

    typedef enum logic [3:0] {
        IDLE, DECODE, GET_ADDR, GET_LEN, GET_DATA, WR_ISSUE,
        RD_ISSUE, RD_WAIT, TX_DATA, ACK, ERR
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          cmd;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] rword;
    logic [8:0]          words;
    logic [7:0]          fld_cnt;
    logic [TmoW-1:0]     tmo_cnt;
    logic                pop, tx_go, tmo, known_cmd, addr_last, data_last, more_words;

    // Handshakes are gated on the previous strobe so each pending byte is taken or sent once.
    assign pop        = (state inside {IDLE, GET_ADDR, GET_LEN, GET_DATA}) && i_rx_rdy && !o_rx_req;
    assign tx_go      = (state inside {TX_DATA, ACK, ERR}) && i_tx_rdy && !o_tx_req;
    assign tmo        = (state inside {GET_ADDR, GET_LEN, GET_DATA}) && !pop
                        && (tmo_cnt == TmoW'(TimeoutCycles - 1));
    assign known_cmd  = cmd inside {CmdWr, CmdRd, CmdBurst};
    assign addr_last  = fld_cnt == 8'(AddrBytes - 1);
    assign data_last  = fld_cnt == 8'(DataBytes - 1);
    assign more_words = words > 9'd1;
    assign o_busy     = state != IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pop) state_nxt = DECODE;
            DECODE:   state_nxt = known_cmd ? GET_ADDR : ERR;
            GET_ADDR: begin
                if (tmo) state_nxt = IDLE;
                else if (pop && addr_last) begin
                    if (cmd == CmdWr)      state_nxt = GET_DATA;
                    else if (cmd == CmdRd) state_nxt = RD_ISSUE;
                    else                   state_nxt = GET_LEN;
                end
            end
            GET_LEN:  if (tmo) state_nxt = IDLE; else if (pop) state_nxt = RD_ISSUE;
            GET_DATA: if (tmo) state_nxt = IDLE; else if (pop && data_last) state_nxt = WR_ISSUE;
            WR_ISSUE: if (i_ctrl_rdy) state_nxt = (EnableAck != 0) ? ACK : IDLE;
            RD_ISSUE: if (i_ctrl_rdy) state_nxt = RD_WAIT;
            RD_WAIT:  if (i_rd_rdy) state_nxt = TX_DATA;
            TX_DATA:  if (tx_go && data_last) state_nxt = more_words ? RD_ISSUE : IDLE;
            ACK:      if (tx_go) state_nxt = IDLE;
            ERR:      if (tx_go) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_req  <= 1'b0;
            o_tx_req  <= 1'b0;
            o_tx_data <= 8'h00;
            o_wr_req  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_rd_req  <= 1'b0;
            o_rd_addr <= '0;
            o_err     <= 1'b0;
            cmd       <= 8'h00;
            addr      <= '0;
            wdata     <= '0;
            rword     <= '0;
            words     <= 9'd0;
            fld_cnt   <= 8'd0;
            tmo_cnt   <= '0;
        end else begin
            o_rx_req <= pop;
            o_tx_req <= 1'b0;
            o_wr_req <= 1'b0;
            o_rd_req <= 1'b0;
            o_err    <= tmo;
            if (pop)                                          tmo_cnt <= '0;
            else if (state inside {GET_ADDR, GET_LEN, GET_DATA}) tmo_cnt <= tmo_cnt + TmoW'(1);
            case (state)
                IDLE: if (pop) cmd <= i_rx_data;
                DECODE: begin
                    fld_cnt <= 8'd0;
                    tmo_cnt <= '0;
                    words   <= 9'd1;
                    o_err   <= !known_cmd;
                end
                GET_ADDR: if (pop) begin
                    addr    <= AddrWidth'({addr, i_rx_data});
                    fld_cnt <= addr_last ? 8'd0 : fld_cnt + 8'd1;
                end
                GET_LEN: if (pop) words <= {1'b0, i_rx_data} + 9'd1;
                GET_DATA: if (pop) begin
                    wdata   <= DataWidth'({wdata, i_rx_data});
                    fld_cnt <= data_last ? 8'd0 : fld_cnt + 8'd1;
                end
                WR_ISSUE: if (i_ctrl_rdy) begin
                    o_wr_req  <= 1'b1;
                    o_wr_addr <= addr;
                    o_wr_data <= wdata;
                end
                RD_ISSUE: if (i_ctrl_rdy) begin
                    o_rd_req  <= 1'b1;
                    o_rd_addr <= addr;
                end
                RD_WAIT: if (i_rd_rdy) begin
                    rword   <= i_rd_data;
                    fld_cnt <= 8'd0;
                end
                TX_DATA: if (tx_go) begin
                    o_tx_req  <= 1'b1;
                    o_tx_data <= rword[DataWidth-1 -: 8];
                    rword     <= rword << 8;
                    if (data_last) begin
                        fld_cnt <= 8'd0;
                        words   <= words - 9'd1;
                        addr    <= addr + AddrWidth'(1);
                    end else begin
                        fld_cnt <= fld_cnt + 8'd1;
                    end
                end
                ACK: if (tx_go) begin
                    o_tx_req  <= 1'b1;
                    o_tx_data <= RespAck;
                end
                ERR: if (tx_go) begin
                    o_tx_req  <= 1'b1;
                    o_tx_data <= RespErr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sdram_bridge.sv
// tb/tb_uart_sdram_bridge.sv - randomized bench for uart_sdram_bridge against a command-level model
module tb_uart_sdram_bridge;
    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int TMO = 40;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_rx_rdy = 1'b0, i_tx_rdy = 1'b0, i_ctrl_rdy = 1'b0, i_rd_rdy = 1'b0;
    logic [DW-1:0] i_rd_data = '0;
    logic          o_rx_req, o_tx_req, o_wr_req, o_rd_req, o_busy, o_err;
    logic [7:0]    o_tx_data;
    logic [AW-1:0] o_wr_addr, o_rd_addr;
    logic [DW-1:0] o_wr_data;

    uart_sdram_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO), .EnableAck(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_rdy(i_rx_rdy), .o_rx_req(o_rx_req),
        .o_tx_data(o_tx_data), .o_tx_req(o_tx_req), .i_tx_rdy(i_tx_rdy), .i_ctrl_rdy(i_ctrl_rdy),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_req(o_rd_req),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_rd_rdy(i_rd_rdy), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;
    logic [7:0]       rx_q[$], tx_got[$], exp_tx[$];
    logic [AW+DW-1:0] wr_log[$], exp_wr[$];
    logic [AW-1:0]    rd_log[$], exp_rd[$];
    bit               err_log[$];
    int               exp_err = 0;
    int               rx_hold = 0, tx_hold = 0, rd_lat = 0;
    bit               rd_pend = 0, tx_en = 1, ctrl_en = 1;
    logic [DW-1:0]    rd_pdata = '0, rd_const = '0;
    int               rd_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a * 7) ^ DW'(a >> 6) ^ 16'hA5C3;
    endfunction

    // Host UART receive side: bytes queued by the test, consumed by o_rx_req.
    always @(posedge clk) begin
        if (!rst_n) rx_hold <= 0;
        else if (o_rx_req) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            rx_hold <= $urandom_range(0, 3);
        end else if (rx_hold != 0) rx_hold <= rx_hold - 1;
    end

    always @(posedge clk) begin
        if (!rst_n) tx_hold <= 0;
        else if (o_tx_req) begin
            tx_got.push_back(o_tx_data);
            tx_hold <= $urandom_range(0, 4);
        end else if (tx_hold != 0) tx_hold <= tx_hold - 1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 0;
            rd_lat  <= 0;
        end else begin
            if (o_err) err_log.push_back(1'b1);
            if (o_wr_req) wr_log.push_back({o_wr_addr, o_wr_data});
            if (o_rd_req) begin
                rd_pdata <= (rd_mode == 0) ? mem_word(o_rd_addr) :
                            (rd_mode == 1) ? DW'(rd_log.size() + 1) : rd_const;
                rd_log.push_back(o_rd_addr);
                rd_pend <= 1;
                rd_lat  <= $urandom_range(1, 6);
            end else if (rd_pend && rd_lat != 0) rd_lat <= rd_lat - 1;
            else if (rd_pend) rd_pend <= 0;
        end
    end

    always @(negedge clk) begin
        i_rx_rdy   = (rx_q.size() != 0) && (rx_hold == 0);
        i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        i_tx_rdy   = tx_en && (tx_hold == 0);
        i_ctrl_rdy = ctrl_en && ($urandom_range(0, 3) != 0);
        i_rd_rdy   = rd_pend && (rd_lat == 0);
        i_rd_data  = rd_pdata;
    end

    task automatic push_addr(input logic [23:0] a);
        rx_q.push_back(a[23:16]); rx_q.push_back(a[15:8]); rx_q.push_back(a[7:0]);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [15:0] d);
        rx_q.push_back(8'h77); push_addr(a); rx_q.push_back(d[15:8]); rx_q.push_back(d[7:0]);
        exp_wr.push_back({a[AW-1:0], d});
        exp_tx.push_back(8'h6B);
    endtask

    task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int c);
        int n;
        int unsigned ea;
        logic [15:0] d;
        rx_q.push_back(op); push_addr(a);
        if (op == 8'h62) rx_q.push_back(8'(c));
        n = (op == 8'h62) ? c + 1 : 1;
        for (int i = 0; i < n; i++) begin
            ea = (int'(a[AW-1:0]) + i) % (1 << AW);
            exp_rd.push_back(AW'(ea));
            d = (rd_mode == 0) ? mem_word(AW'(ea)) : (rd_mode == 1) ? 16'(i + 1) : rd_const;
            exp_tx.push_back(d[15:8]); exp_tx.push_back(d[7:0]);
        end
    endtask

    task automatic do_bad(input logic [7:0] b);
        rx_q.push_back(b);
        exp_err++;
        exp_tx.push_back(8'h3F);
    endtask

    task automatic settle();
        int quiet = 0, n = 0;
        while (quiet < 8 && n < 20000) begin
            @(negedge clk); n++;
            if (rx_q.size() == 0 && !o_busy) quiet++; else quiet = 0;
        end
        check("settle_bound", n < 20000, 1);
    endtask

    task automatic clear_all();
        tx_got.delete(); exp_tx.delete(); wr_log.delete(); exp_wr.delete();
        rd_log.delete(); exp_rd.delete(); err_log.delete(); exp_err = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":tx_n"}, tx_got.size(), exp_tx.size());
        for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++) check({tag, ":tx"}, tx_got[i], exp_tx[i]);
        check({tag, ":wr_n"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) check({tag, ":wr"}, wr_log[i], exp_wr[i]);
        check({tag, ":rd_n"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) check({tag, ":rd"}, rd_log[i], exp_rd[i]);
        check({tag, ":err_n"}, err_log.size(), exp_err);
        clear_all();
    endtask

    initial begin
        int n, kind;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {o_rx_req, o_tx_req, o_wr_req, o_rd_req, o_busy, o_err}, 0);
        check("rst_data", {o_tx_data, o_wr_data}, 0);
        check("rst_addr", {o_wr_addr, o_rd_addr}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_write(24'h123456, 16'hABCD); settle(); compare_all("wr_dir");
        rd_mode = 2; rd_const = 16'hBEEF;
        do_read(8'h72, 24'h3FFFFF, 0); settle(); compare_all("rd_dir");
        rd_mode = 1;
        do_read(8'h62, 24'h3FFFFE, 2); settle(); compare_all("burst_wrap");
        rd_mode = 0;
        do_bad(8'h41); settle(); compare_all("bad_cmd");

        rx_q.push_back(8'h77); rx_q.push_back(8'h12);
        n = 0;
        while (rx_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!o_err && n < TMO + 20) begin @(negedge clk); n++; end
        check("tmo_lat_lo", n >= TMO - 3, 1);
        check("tmo_lat_hi", n <= TMO + 1, 1);
        exp_err = 1; settle(); compare_all("timeout");

        ctrl_en = 0;
        do_write(24'hC0FFEE, 16'h1234);
        repeat (60) @(negedge clk);
        check("bp_wr_held", wr_log.size(), 0);
        check("bp_wr_busy", o_busy, 1);
        ctrl_en = 1; settle(); compare_all("bp_wr");
        tx_en = 0;
        do_read(8'h72, 24'h00ABCD, 0);
        repeat (60) @(negedge clk);
        check("bp_tx_held", tx_got.size(), 0);
        check("bp_tx_busy", o_busy, 1);
        tx_en = 1; settle(); compare_all("bp_tx");

        do_read(8'h62, 24'h3FFF80, 255); settle(); compare_all("burst_256");

        for (int k = 0; k < 25; k++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) do_write(24'($urandom), 16'($urandom));
            else if (kind == 1) do_read(8'h72, 24'($urandom), 0);
            else if (kind == 2) do_read(8'h62, 24'($urandom), $urandom_range(0, 7));
            else begin
                b = 8'($urandom);
                if (b == 8'h77 || b == 8'h72 || b == 8'h62) b = 8'h00;
                do_bad(b);
            end
            settle(); compare_all("rand");
        end

        do_read(8'h62, 24'h001000, 3);
        n = 0;
        while (!o_rd_req && n < 500) begin @(negedge clk); n++; end
        check("arst_reach", o_rd_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {o_rx_req, o_tx_req, o_wr_req, o_rd_req, o_busy, o_err}, 0);
        check("arst_data", {o_tx_data, o_wr_data, o_wr_addr, o_rd_addr}, 0);
        rx_q.delete(); clear_all();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(8'h72, 24'h2A5A5A, 0); settle(); compare_all("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
